rip_cnt_sampler: RTL and testbench

//  Downstream consumer of the 4-bit ripple counter. Samples its asynchronous, glitch-prone

---
 rtl/rip_cnt_pkg.sv | 15 +
 rtl/rip_cnt_sync.sv | 46 ++++
 rtl/rip_cnt_sampler.sv | 116 +++++++++++
 tb/tb_rip_cnt_sampler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rip_cnt_pkg.sv
// Shared definitions for the ripple-counter sampler: tracker state encoding and default widths.
package rip_cnt_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int CNT_W_DEF         = 4;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 2;
    localparam int EXT_W_DEF         = 16;
    localparam int DLT_W_DEF         = 6;

endpackage

// File: rtl/rip_cnt_sync.sv
// Brings the asynchronous ripple count into the clk domain and only accepts a value once it
// has been seen unchanged for enough consecutive synchronized samples.
module rip_cnt_sync
    import rip_cnt_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CNT_W-1:0] count_in,
    output logic             accept,
    output logic [CNT_W-1:0] acc_val
);

    localparam int STAB_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][CNT_W-1:0] sync_q;
    logic [CNT_W-1:0]                  s;
    logic [CNT_W-1:0]                  cand;
    logic [STAB_W-1:0]                 stab;

    assign s = sync_q[SYNC_STAGES-1];

    // stab saturates at STABLE_CYCLES so a long-held value produces exactly one accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            cand   <= '0;
            stab   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], count_in};
            if (s != cand) begin
                cand <= s;
                stab <= '0;
            end else if (stab < STAB_W'(STABLE_CYCLES)) begin
                stab <= stab + 1'b1;
            end
        end
    end

    assign accept  = (s == cand) && (stab == STAB_W'(STABLE_CYCLES - 1));
    assign acc_val = cand;

endmodule

// File: rtl/rip_cnt_sampler.sv
// Turns filtered ripple-counter values into a wrap-extended count and a saturating
// increment accumulator handed to a consumer over valid/ready.
module rip_cnt_sampler
    import rip_cnt_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int EXT_W         = EXT_W_DEF,
    parameter int DLT_W         = DLT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [CNT_W-1:0] count_in,
    output logic [EXT_W-1:0] ext_count,
    output logic             wrap,
    output logic [DLT_W-1:0] delta,
    output logic             delta_valid,
    input  logic             delta_ready,
    output logic             ovf
);

    logic             accept;
    logic [CNT_W-1:0] acc_val;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [EXT_W-1:0] ext_q;
    logic [DLT_W-1:0] pend_q, pend_base;
    logic [DLT_W:0]   pend_sum;
    logic [CNT_W-1:0] step;
    logic             wrap_q, wrap_d;
    logic             ovf_q;
    logic             xfer;

    rip_cnt_sync #(
        .CNT_W         (CNT_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .count_in (count_in),
        .accept   (accept),
        .acc_val  (acc_val)
    );

    // The first accepted value after INIT is only a baseline; modular subtraction absorbs wrap
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        step    = '0;
        wrap_d  = 1'b0;
        if (accept) begin
            case (state_q)
                INIT: begin
                    last_d  = acc_val;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (acc_val != last_q) begin
                        step   = acc_val - last_q;
                        wrap_d = (acc_val < last_q);
                        last_d = acc_val;
                    end
                end
                default: ;
            endcase
        end
        if (clr) begin
            state_d = INIT;
            step    = '0;
            wrap_d  = 1'b0;
        end
    end

    assign xfer      = delta_valid && delta_ready;
    assign pend_base = xfer ? '0 : pend_q;
    assign pend_sum  = {1'b0, pend_base} + {{(DLT_W + 1 - CNT_W){1'b0}}, step};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT;
            last_q  <= '0;
            ext_q   <= '0;
            pend_q  <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wrap_q  <= wrap_d;
            if (clr) begin
                ext_q  <= '0;
                pend_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                ext_q <= ext_q + {{(EXT_W - CNT_W){1'b0}}, step};
                if (pend_sum[DLT_W]) begin
                    pend_q <= '1;
                    ovf_q  <= 1'b1;
                end else begin
                    pend_q <= pend_sum[DLT_W-1:0];
                end
            end
        end
    end

    assign ext_count   = ext_q;
    assign wrap        = wrap_q;
    assign delta       = pend_q;
    assign delta_valid = (pend_q != '0);
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_rip_cnt_sampler.sv
// Directed scenarios plus randomized hold lengths, ready and clr, all checked cycle by cycle
// against a run-length based reference model of the sampler.
module tb_rip_cnt_sampler;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic [3:0]  count_in;
    logic [15:0] ext_count;
    logic        wrap;
    logic [5:0]  delta;
    logic        delta_valid;
    logic        delta_ready;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    // Reference model: h[k] is the count driven before the k-th most recent edge
    int h [6];
    bit m_base;
    int m_last, m_ext, m_pend;
    bit m_ovf, m_wrap;

    int xfer_cnt, xfer_sum, xfer_last, wrap_cnt;

    rip_cnt_sampler dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .count_in    (count_in),
        .ext_count   (ext_count),
        .wrap        (wrap),
        .delta       (delta),
        .delta_valid (delta_valid),
        .delta_ready (delta_ready),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A cleared sync chain looks like a run of zeros already two samples old
    task automatic modelReset();
        h = '{0, 0, 0, 16, 16, 16};
        m_base = 0; m_last = 0; m_ext = 0; m_pend = 0; m_ovf = 0; m_wrap = 0;
    endtask

    // A value is accepted once, when it has been driven for three consecutive edges
    task automatic modelEdge(input int cin, input bit rdy, input bit c);
        bit acc, xf;
        int v, step, sum;
        for (int k = 5; k > 0; k--) h[k] = h[k-1];
        h[0] = cin;
        acc  = (h[4] == h[3]) && (h[3] == h[2]) && (h[5] != h[4]);
        v    = h[4];
        xf   = (m_pend != 0) && rdy;
        step = 0;
        m_wrap = 0;
        if (c) begin
            m_ext = 0; m_pend = 0; m_ovf = 0; m_base = 0;
        end else begin
            if (acc) begin
                if (!m_base) begin
                    m_base = 1;
                    m_last = v;
                end else if (v != m_last) begin
                    step   = (v - m_last + 16) % 16;
                    m_wrap = (v < m_last);
                    m_last = v;
                end
            end
            m_ext = (m_ext + step) % 65536;
            sum   = (xf ? 0 : m_pend) + step;
            if (sum > 63) begin
                m_pend = 63;
                m_ovf  = 1;
            end else begin
                m_pend = sum;
            end
        end
    endtask

    task automatic applyStimulus(input int cnt, input bit rdy, input bit c);
        count_in    = 4'(cnt);
        delta_ready = rdy;
        clr         = c;
        if (delta_valid && rdy) begin
            xfer_cnt++;
            xfer_sum += int'(delta);
            xfer_last = int'(delta);
        end
        @(posedge clk);
        modelEdge(cnt, rdy, c);
        #1;
        if (wrap) wrap_cnt++;
        checkOutput("ext",   32'(ext_count),   32'(m_ext));
        checkOutput("delta", 32'(delta),       32'(m_pend));
        checkOutput("dv",    32'(delta_valid), 32'(m_pend != 0));
        checkOutput("wrap",  32'(wrap),        32'(m_wrap));
        checkOutput("ovf",   32'(ovf),         32'(m_ovf));
    endtask

    task automatic hold(input int cnt, input bit rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(cnt, rdy, 1'b0);
    endtask

    task automatic clearCounters();
        xfer_cnt = 0; xfer_sum = 0; xfer_last = -1; wrap_cnt = 0;
    endtask

    initial begin
        int prev, v, len, bias;
        rstn = 1'b0; clr = 1'b0; count_in = '0; delta_ready = 1'b0;
        clearCounters();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Build up pending=3 under backpressure, then reset mid-cycle
        hold(0, 0, 8);
        hold(1, 0, 6);
        hold(2, 0, 6);
        hold(3, 0, 6);
        checkOutput("pre_reset_delta", 32'(delta), 32'd3);
        #2;
        rstn = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_ext",   32'(ext_count),   32'd0);
        checkOutput("rst_delta", 32'(delta),       32'd0);
        checkOutput("rst_dv",    32'(delta_valid), 32'd0);
        checkOutput("rst_wrap",  32'(wrap),        32'd0);
        checkOutput("rst_ovf",   32'(ovf),         32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Cleared chain gives a zero baseline; clr re-baselines so held 5 only sets baseline
        applyStimulus(5, 0, 0);
        applyStimulus(5, 0, 0);
        applyStimulus(5, 0, 1);
        hold(5, 0, 8);
        checkOutput("t1_ext", 32'(ext_count),   32'd0);
        checkOutput("t1_dv",  32'(delta_valid), 32'd0);

        // Single steps with 5-edge latency
        applyStimulus(5, 1, 1);
        hold(0, 1, 8);
        clearCounters();
        for (int n = 1; n <= 3; n++) begin
            hold(n, 1, 4);
            checkOutput("t2_lat_pre", 32'(ext_count), 32'(n - 1));
            applyStimulus(n, 1, 0);
            checkOutput("t2_lat_post", 32'(ext_count), 32'(n));
            hold(n, 1, 3);
        end
        hold(3, 1, 2);
        checkOutput("t2_ext",   32'(ext_count), 32'd3);
        checkOutput("t2_xfers", 32'(xfer_cnt),  32'd3);
        checkOutput("t2_xsum",  32'(xfer_sum),  32'd3);

        // One-cycle ripple transient is ignored
        applyStimulus(3, 1, 1);
        hold(7, 1, 8);
        clearCounters();
        applyStimulus(6, 1, 0);
        hold(8, 1, 10);
        checkOutput("t3_ext",   32'(ext_count), 32'd1);
        checkOutput("t3_xfers", 32'(xfer_cnt),  32'd1);
        checkOutput("t3_xsum",  32'(xfer_sum),  32'd1);

        // Wrap through zero
        applyStimulus(8, 1, 1);
        hold(14, 1, 8);
        clearCounters();
        hold(15, 1, 8);
        hold(0, 1, 8);
        hold(1, 1, 8);
        checkOutput("t4_ext",  32'(ext_count), 32'd3);
        checkOutput("t4_wrap", 32'(wrap_cnt),  32'd1);

        // Saturation under backpressure
        applyStimulus(1, 0, 1);
        hold(0, 0, 8);
        for (int i = 1; i <= 70; i++) hold(i % 16, 0, 3);
        hold(6, 0, 5);
        checkOutput("t5_ext",   32'(ext_count), 32'd70);
        checkOutput("t5_delta", 32'(delta),     32'd63);
        checkOutput("t5_ovf",   32'(ovf),       32'd1);
        clearCounters();
        applyStimulus(6, 1, 0);
        checkOutput("t5_xfer", 32'(xfer_last),   32'd63);
        checkOutput("t5_dv",   32'(delta_valid), 32'd0);
        applyStimulus(6, 0, 1);
        checkOutput("t5_clr_ovf", 32'(ovf),       32'd0);
        checkOutput("t5_clr_ext", 32'(ext_count), 32'd0);

        // Transfer coincides with a new step
        hold(0, 0, 8);
        hold(2, 0, 6);
        checkOutput("t6_pend", 32'(delta), 32'd2);
        clearCounters();
        hold(3, 0, 4);
        applyStimulus(3, 1, 0);
        checkOutput("t6_xfer",  32'(xfer_last), 32'd2);
        checkOutput("t6_delta", 32'(delta),     32'd1);
        hold(3, 1, 3);

        // Randomized holds, ready and clr
        prev = 3;
        for (int seg = 0; seg < 400; seg++) begin
            do v = $urandom_range(0, 15); while (v == prev);
            len  = $urandom_range(1, 6);
            bias = $urandom_range(0, 4);
            for (int i = 0; i < len; i++)
                applyStimulus(v, ($urandom_range(0, 3) < bias), ($urandom_range(0, 149) == 0));
            prev = v;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
